// File: rtl/alu_rr_sched.sv
// alu_rr_sched
//   Shares one registered ALU between two requesters. A round-robin arbiter
//   grants one command at a time in IDLE. The command is latched, executed in
//   EXEC, and returned with the owner's ID as a one-cycle strobe in DONE.
//
// Ports
//   clk                       rising-edge clock
//   rst                       asynchronous, active-high reset
//   req0_valid / req0_ready   requester 0 handshake (ready is combinational)
//   req0_op, req0_a, req0_b   requester 0 opcode and operands
//   req1_*                    same as requester 0, for requester 1
//   rsp_valid                 one-cycle result strobe (state DONE)
//   rsp_id                    requester that owns the result
//   rsp_y                     result, WIDTH bits, wraps modulo 2^WIDTH
//   rsp_cout                  carry (ADD), not-borrow (SUB), else 0
//   rsp_zero                  rsp_y == 0
module alu_rr_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_y,
   output logic             rsp_cout,
   output logic             rsp_zero
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic             last_grant;
   logic             grant;
   logic             accept;

   logic [2:0]       op_p0;
   logic [WIDTH-1:0] a_p0;
   logic [WIDTH-1:0] b_p0;
   logic             id_p0;

   logic [WIDTH:0]   res_p1;

   // Returns {carry_flag, result}. For SUB the top bit of the WIDTH+1 bit
   // difference is a borrow, so it is inverted to give not-borrow.
   function automatic logic [WIDTH:0] alu_eval(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      logic [WIDTH:0] r;
      r = '0;
      case (op)
         3'b000:  r = {1'b0, a & b};
         3'b001:  r = {1'b0, a | b};
         3'b010:  r = {1'b0, a ^ b};
         3'b011:  r = {1'b0, ~a};
         3'b100:  r = {1'b0, a} + {1'b0, b};
         3'b101:  begin
            r         = {1'b0, a} - {1'b0, b};
            r[WIDTH]  = ~r[WIDTH];
         end
         3'b110:  r = {{WIDTH{1'b0}}, &a[3:0]};
         default: r = {1'b0, a};
      endcase
      return r;
   endfunction

   // With both valid, the requester that did not win last time goes next.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   // rst gating keeps both readys low while reset is held, even though the
   // state register already sits at IDLE during that time.
   assign req0_ready = (state == IDLE) && !rst && !grant && req0_valid;
   assign req1_ready = (state == IDLE) && !rst &&  grant && req1_valid;
   assign accept     = req0_ready || req1_ready;
   assign rsp_valid  = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= EXEC;
                  last_grant <= req1_ready;
               end
            end
            EXEC:    state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   // Stage p0: command capture on the handshake
   always_ff @(posedge clk) begin
      if (accept) begin
         op_p0 <= req1_ready ? req1_op : req0_op;
         a_p0  <= req1_ready ? req1_a  : req0_a;
         b_p0  <= req1_ready ? req1_b  : req0_b;
         id_p0 <= req1_ready;
      end
   end

   // Stage p1: execute into the response registers
   assign res_p1 = alu_eval(op_p0, a_p0, b_p0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_id   <= 1'b0;
         rsp_y    <= '0;
         rsp_cout <= 1'b0;
         rsp_zero <= 1'b0;
      end else if (state == EXEC) begin
         rsp_id   <= id_p0;
         rsp_y    <= res_p1[WIDTH-1:0];
         rsp_cout <= res_p1[WIDTH];
         rsp_zero <= (res_p1[WIDTH-1:0] == '0);
      end
   end

endmodule
